// File: rtl/wb_wport_arbiter.sv
// wb_wport_arbiter
// Shares the single register-file write port between the in-order writeback
// stream and a long-latency unit (div/mul). Long-latency results are queued in
// a small FIFO. The writeback stream normally wins arbitration. If the FIFO
// head loses for STARVE_LIMIT cycles in a row, one forced LU grant follows.
// The committed write is registered once and drives the decode forward bus and
// the debug trace.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   wb_valid/wb_ready  writeback request / accepted this cycle
//   wb_we, wb_dest, wb_data, wb_pc   writeback payload
//   lu_valid/lu_ready  long-latency result push / FIFO not full
//   lu_dest, lu_data, lu_pc          long-latency payload
//   ws_to_ds_bus       {we, waddr[4:0], wdata[31:0]} to decode / RF
//   debug_wb_*         trace of the committed write (pc, {4{we}}, wnum, wdata)
module wb_wport_arbiter #(
  parameter int LU_DEPTH     = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  output logic        wb_ready,
  input  logic        wb_we,
  input  logic [4:0]  wb_dest,
  input  logic [31:0] wb_data,
  input  logic [31:0] wb_pc,
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_dest,
  input  logic [31:0] lu_data,
  input  logic [31:0] lu_pc,
  output logic [37:0] ws_to_ds_bus,
  output logic [31:0] debug_wb_pc,
  output logic [3:0]  debug_wb_rf_we,
  output logic [4:0]  debug_wb_rf_wnum,
  output logic [31:0] debug_wb_rf_wdata
);

  localparam int AW = $clog2(LU_DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_LIMIT - 1);

  typedef enum logic {NORMAL, FORCE_LU} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;

  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  logic [4:0]  fifo_dest_q [LU_DEPTH];
  logic [31:0] fifo_data_q [LU_DEPTH];
  logic [31:0] fifo_pc_q   [LU_DEPTH];
  logic [AW:0] wptr_q, rptr_q;

  logic empty, full, push, pop;
  logic grant_wb, grant_lu;

  logic        we_q, we_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] pc_q, pc_d;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign lu_ready = !full;
  // The push decision ignores a pop in the same cycle. The FIFO never accepts
  // a write while it is full.
  assign push     = lu_valid && !full;
  assign pop      = grant_lu;
  assign wb_ready = grant_wb;

  always_comb begin
    grant_wb = 1'b0;
    grant_lu = 1'b0;
    if (state_q == FORCE_LU) begin
      grant_lu = !empty;
    end else if (wb_valid) begin
      grant_wb = 1'b1;
    end else begin
      grant_lu = !empty;
    end
  end

  // Count the cycles in a row that the FIFO head loses. The force state always
  // lasts exactly one cycle.
  always_comb begin
    state_d  = NORMAL;
    starve_d = '0;
    if (state_q == NORMAL && !empty && !grant_lu) begin
      if (starve_q == CNT_MAX) begin
        state_d = FORCE_LU;
      end else begin
        starve_d = starve_q + CW'(1);
      end
    end
  end

  // Build the write for the output register. A write to r0 never sets we, but
  // its pc is still traced.
  always_comb begin
    we_d    = 1'b0;
    waddr_d = '0;
    wdata_d = '0;
    pc_d    = '0;
    if (grant_wb) begin
      we_d    = wb_we && (wb_dest != 5'd0);
      waddr_d = wb_dest;
      wdata_d = wb_data;
      pc_d    = wb_pc;
    end else if (grant_lu) begin
      we_d    = (fifo_dest_q[rptr_q[AW-1:0]] != 5'd0);
      waddr_d = fifo_dest_q[rptr_q[AW-1:0]];
      wdata_d = fifo_data_q[rptr_q[AW-1:0]];
      pc_d    = fifo_pc_q[rptr_q[AW-1:0]];
    end
  end

  // Arbitration state and output register stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= NORMAL;
      starve_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      we_q     <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      we_q     <= we_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
      pc_q     <= pc_d;
    end
  end

  // FIFO storage; contents are qualified by the pointers, so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_dest_q[wptr_q[AW-1:0]] <= lu_dest;
      fifo_data_q[wptr_q[AW-1:0]] <= lu_data;
      fifo_pc_q[wptr_q[AW-1:0]]   <= lu_pc;
    end
  end

  assign ws_to_ds_bus      = {we_q, waddr_q, wdata_q};
  assign debug_wb_pc       = pc_q;
  assign debug_wb_rf_we    = {4{we_q}};
  assign debug_wb_rf_wnum  = waddr_q;
  assign debug_wb_rf_wdata = wdata_q;

endmodule

// File: tb/tb_wb_wport_arbiter.sv
// Testbench for wb_wport_arbiter. A queue-based reference model tracks the
// long-latency FIFO and the consecutive-loss count. It is checked against the
// DUT on every negative clock edge. Directed scenarios add literal
// expectations that were computed by hand.
module tb_wb_wport_arbiter;
  localparam int LU_DEPTH     = 2;
  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid, wb_ready, wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data, wb_pc;
  logic        lu_valid, lu_ready;
  logic [4:0]  lu_dest;
  logic [31:0] lu_data, lu_pc;
  logic [37:0] ws_to_ds_bus;
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_we;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;

  always #5 clk = ~clk;

  wb_wport_arbiter #(.LU_DEPTH(LU_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
    .wb_dest(wb_dest), .wb_data(wb_data), .wb_pc(wb_pc),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_dest(lu_dest),
    .lu_data(lu_data), .lu_pc(lu_pc),
    .ws_to_ds_bus(ws_to_ds_bus), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: FIFO as a queue, a loss counter and a one-shot force flag.
  typedef struct packed {
    logic [4:0]  dest;
    logic [31:0] data;
    logic [31:0] pc;
  } lu_ent_t;

  lu_ent_t     q[$];
  int          losses   = 0;
  bit          force_lu = 1'b0;
  bit          mv       = 1'b0;
  logic [37:0] e_bus    = '0;
  logic [31:0] e_pc     = '0;

  always @(negedge clk) begin
    if (mv) begin
      check("bus",       64'(ws_to_ds_bus),      64'(e_bus));
      check("dbg_pc",    64'(debug_wb_pc),       64'(e_pc));
      check("dbg_we",    64'(debug_wb_rf_we),    64'({4{e_bus[37]}}));
      check("dbg_wnum",  64'(debug_wb_rf_wnum),  64'(e_bus[36:32]));
      check("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(e_bus[31:0]));
      check("wb_ready",  64'(wb_ready),          64'(wb_valid && !force_lu));
      check("lu_ready",  64'(lu_ready),          64'(q.size() < LU_DEPTH));
    end
    if (reset) begin
      q.delete();
      losses   = 0;
      force_lu = 1'b0;
      e_bus    = '0;
      e_pc     = '0;
      mv       = 1'b1;
    end else if (mv) begin
      bit      can_push, gwb, glu, had_entry;
      lu_ent_t h;
      can_push  = (q.size() < LU_DEPTH);
      had_entry = (q.size() > 0);
      gwb       = !force_lu && wb_valid;
      glu       = !gwb && had_entry;
      if (gwb) begin
        e_bus = {wb_we && (wb_dest != 5'd0), wb_dest, wb_data};
        e_pc  = wb_pc;
      end else if (glu) begin
        h     = q.pop_front();
        e_bus = {h.dest != 5'd0, h.dest, h.data};
        e_pc  = h.pc;
      end else begin
        e_bus = '0;
        e_pc  = '0;
      end
      if (force_lu) begin
        force_lu = 1'b0;
        losses   = 0;
      end else if (had_entry && !glu) begin
        losses++;
        if (losses == STARVE_LIMIT) begin
          force_lu = 1'b1;
          losses   = 0;
        end
      end else begin
        losses = 0;
      end
      if (lu_valid && can_push) q.push_back('{dest: lu_dest, data: lu_data, pc: lu_pc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    bit  done;
    reset = 1'b1; wb_valid = 1'b0; wb_we = 1'b0; wb_dest = '0; wb_data = '0; wb_pc = '0;
    lu_valid = 1'b0; lu_dest = '0; lu_data = '0; lu_pc = '0;
    tick(); tick();
    reset = 1'b0;

    // Reset state and idle
    check("t1_bus",      64'(ws_to_ds_bus),   64'(0));
    check("t1_dbg_we",   64'(debug_wb_rf_we), 64'(0));
    check("t1_lu_ready", 64'(lu_ready),       64'(1));
    tick();

    // Plain writeback write
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd5; wb_data = 32'h1234; wb_pc = 32'h1c000000;
    #1 check("t1_wb_ready", 64'(wb_ready), 64'(1));
    tick();
    wb_valid = 1'b0;
    check("t2_bus",    64'(ws_to_ds_bus),   64'({1'b1, 5'd5, 32'h1234}));
    check("t2_dbg_we", 64'(debug_wb_rf_we), 64'(4'hf));
    check("t2_dbg_pc", 64'(debug_wb_pc),    64'(32'h1c000000));

    // Single LU result with the writeback stream idle
    lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 32'hAB; lu_pc = 32'h1c000100;
    tick();
    lu_valid = 1'b0;
    check("t3_bus_push", 64'(ws_to_ds_bus), 64'(0));
    tick();
    check("t3_bus_pop",  64'(ws_to_ds_bus), 64'({1'b1, 5'd7, 32'hAB}));
    check("t3_dbg_pc",   64'(debug_wb_pc),  64'(32'h1c000100));

    // Starvation: WB valid every cycle, LU forced through on the 5th cycle
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd3; wb_data = 32'h100; wb_pc = 32'h1c000200;
    lu_valid = 1'b1; lu_dest = 5'd9; lu_data = 32'h99; lu_pc = 32'h1c000300;
    tick();
    lu_valid = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      wb_data = 32'h100 + 32'(i);
      #1 check("t4_wb_ready", 64'(wb_ready), 64'(i < 5));
      tick();
      if (i < 5) check("t4_bus_wb", 64'(ws_to_ds_bus), 64'({1'b1, 5'd3, 32'h100 + 32'(i)}));
      else       check("t4_bus_lu", 64'(ws_to_ds_bus), 64'({1'b1, 5'd9, 32'h99}));
    end
    wb_valid = 1'b0;
    tick();

    // Fill the FIFO while WB is busy; the third result must be held, not lost
    wb_valid = 1'b1; wb_dest = 5'd2; wb_data = 32'h500; wb_pc = 32'h1c000400;
    lu_valid = 1'b1; lu_dest = 5'd10; lu_data = 32'hA0; lu_pc = 32'h1c000500;
    #1 check("t5_ready_a", 64'(lu_ready), 64'(1));
    tick();
    lu_dest = 5'd11; lu_data = 32'hB0; lu_pc = 32'h1c000504;
    #1 check("t5_ready_b", 64'(lu_ready), 64'(1));
    tick();
    lu_dest = 5'd12; lu_data = 32'hC0; lu_pc = 32'h1c000508;
    #1 check("t5_ready_full", 64'(lu_ready), 64'(0));
    done = 1'b0;
    k = 0;
    while (!done && k < 20) begin
      #1;
      if (lu_ready) done = 1'b1;
      else k++;
      tick();
    end
    check("t5_hold_cycles", 64'(k), 64'(4));
    lu_valid = 1'b0; wb_valid = 1'b0;
    tick();
    check("t5_drain_b", 64'(ws_to_ds_bus), 64'({1'b1, 5'd11, 32'hB0}));
    tick();
    check("t5_drain_c", 64'(ws_to_ds_bus), 64'({1'b1, 5'd12, 32'hC0}));
    tick();

    // r0 write is suppressed but traced; wb_we=0 retirement is traced too
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd0; wb_data = 32'hDEAD; wb_pc = 32'h1c000010;
    tick();
    check("t6_dbg_we", 64'(debug_wb_rf_we), 64'(0));
    check("t6_dbg_pc", 64'(debug_wb_pc),    64'(32'h1c000010));
    wb_we = 1'b0; wb_dest = 5'd4; wb_data = 32'h44; wb_pc = 32'h1c000020;
    tick();
    wb_valid = 1'b0;
    check("t6_nowe_we", 64'(debug_wb_rf_we), 64'(0));
    check("t6_nowe_pc", 64'(debug_wb_pc),    64'(32'h1c000020));

    // LU result to r0
    lu_valid = 1'b1; lu_dest = 5'd0; lu_data = 32'h77; lu_pc = 32'h1c000600;
    tick();
    lu_valid = 1'b0;
    tick();
    check("t7_lu_r0_bus", 64'(ws_to_ds_bus), 64'({1'b0, 5'd0, 32'h77}));
    check("t7_lu_r0_pc",  64'(debug_wb_pc),  64'(32'h1c000600));

    // Reset mid-operation discards queued results
    wb_valid = 1'b1; wb_we = 1'b1; wb_dest = 5'd6; wb_data = 32'h600; wb_pc = 32'h1c000700;
    lu_valid = 1'b1; lu_dest = 5'd8; lu_data = 32'h88; lu_pc = 32'h1c000800;
    tick();
    lu_valid = 1'b0; wb_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t8_rst_bus", 64'(ws_to_ds_bus), 64'(0));
    tick();
    tick();
    check("t8_no_stale_lu", 64'(ws_to_ds_bus), 64'(0));
    check("t8_lu_ready",    64'(lu_ready),     64'(1));

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
